// File: rtl/mult_sequencer_if.sv
// Decoder-facing bundle for the iterative HI/LO multiplier: issue, operands,
// HI/LO read port and pipeline handshake.
interface mult_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic             rd_req;
  logic             rd_sel;
  logic [WIDTH-1:0] rd_data;
  logic             busy;
  logic             done;
  logic             stall;

  modport master (
    output start, srca, srcb, rd_req, rd_sel,
    input  rd_data, busy, done, stall
  );

  modport slave (
    input  start, srca, srcb, rd_req, rd_sel,
    output rd_data, busy, done, stall
  );
endinterface

// File: rtl/mult_sequencer.sv
// Shift-add unsigned multiplier (one multiplier bit per cycle) that writes
// the architectural HI/LO pair and stalls the pipeline while a result is pending.
module mult_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  mult_sequencer_if.slave   bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_reg, state_next;
  logic [2*WIDTH-1:0] acc_reg, acc_next;
  logic [2*WIDTH-1:0] mcand_reg, mcand_next;
  logic [WIDTH-1:0]   mplier_reg, mplier_next;
  logic [WIDTH-1:0]   hi_reg, hi_next;
  logic [WIDTH-1:0]   lo_reg, lo_next;
  logic [CW-1:0]      count_reg, count_next;
  logic [2*WIDTH-1:0] addend;
  logic [2*WIDTH-1:0] sum;
  logic               accept;
  logic               last_iter;

  // Partial product for this iteration: multiplicand gated by the current multiplier LSB.
  genvar gi;
  generate
    for (gi = 0; gi < 2*WIDTH; gi++) begin : g_addend
      assign addend[gi] = mcand_reg[gi] & mplier_reg[0];
    end
  endgenerate

  assign sum       = acc_reg + addend;
  assign last_iter = (count_reg == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // DONE accepts a new start exactly like IDLE, giving back-to-back issue.
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (last_iter) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    acc_next    = acc_reg;
    mcand_next  = mcand_reg;
    mplier_next = mplier_reg;
    count_next  = count_reg;
    hi_next     = hi_reg;
    lo_next     = lo_reg;
    if (accept) begin
      acc_next    = '0;
      mcand_next  = {{WIDTH{1'b0}}, bus.srca};
      mplier_next = bus.srcb;
      count_next  = '0;
    end else if (state_reg == RUN) begin
      acc_next    = sum;
      mcand_next  = mcand_reg << 1;
      mplier_next = mplier_reg >> 1;
      count_next  = count_reg + 1'b1;
      if (last_iter) begin
        hi_next = sum[2*WIDTH-1:WIDTH];
        lo_next = sum[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      count_reg  <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
    end else begin
      acc_reg    <= acc_next;
      mcand_reg  <= mcand_next;
      mplier_reg <= mplier_next;
      count_reg  <= count_next;
      hi_reg     <= hi_next;
      lo_reg     <= lo_next;
    end
  end

  // Stall only while RUN: in DONE the new product is already readable.
  assign bus.busy    = (state_reg == RUN);
  assign bus.done    = (state_reg == DONE);
  assign bus.stall   = bus.busy & (bus.rd_req | bus.start);
  assign bus.rd_data = bus.rd_sel ? hi_reg : lo_reg;
endmodule

// File: doc/mult_sequencer.md
Name: mult_sequencer

Overview:
- Iterative shift-add unsigned multiplier with architectural HI/LO registers.
- Executes `multu`, and serves `mfhi`/`mflo` reads.
- Sits beside the ALU. The decoder issues `start` on multiply and `rd_req` on move-from-HI/LO.
- `stall` freezes the PC/pipeline until a pending result is available.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits; product is 2*WIDTH bits.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  issue multiply; operands sampled on the same edge when accepted
- srca  input  WIDTH  multiplicand (rs)
- srcb  input  WIDTH  multiplier (rt)
- rd_req  input  1  instruction reads HI or LO this cycle
- rd_sel  input  1  0 = LO, 1 = HI
- rd_data  output  WIDTH  selected HI/LO value (combinational from registers)
- busy  output  1  multiply in progress (state RUN)
- done  output  1  one-cycle pulse; HI/LO hold the new product this cycle
- stall  output  1  hold pipeline this cycle

Behaviour:
- Clock and reset: one clock `clk`; `reset` is asynchronous, active-high. Assertion forces immediately:
  - state = IDLE, HI = LO = 0, acc = 0, mcand = 0, mplier = 0, count = 0
  - `busy` = `done` = `stall` = 0; `rd_data` = 0
- States: IDLE, RUN, DONE.
- IDLE, start = 1 (edge E0):
  - mcand <= zero-extended srca (2*WIDTH bits)
  - mplier <= srcb
  - acc <= 0, count <= 0, go to RUN
- RUN, each edge:
  - acc_next = acc + (mplier[0] ? mcand : 0), computed mod 2^(2*WIDTH)
  - acc <= acc_next; mcand <= mcand << 1; mplier <= mplier >> 1; count <= count + 1
  - count is $clog2(WIDTH) bits.
- Last iteration (edge E_WIDTH, count == WIDTH-1):
  - HI <= acc_next[2W-1:W], LO <= acc_next[W-1:0]
  - go to DONE. HI/LO change only on this edge or on reset.
- DONE: `done` = 1 for exactly one cycle.
  - Next edge: go to IDLE, unless start = 1, in which case the new operation is accepted exactly as from IDLE (back-to-back issue).
- Latency: start accepted at E0; iterations at E1..E_WIDTH; `done` high during the cycle after E_WIDTH. Fixed, no early termination.
- busy = (state == RUN).
- stall = busy & (rd_req | start).
  - Reads of HI/LO are held while a result is pending.
  - A new `multu` is held while one is running.
  - start during RUN is ignored: operands are not relatched and the current operation continues. The pipeline re-presents it after the stall drops.
- rd_data = rd_sel ? HI : LO, at all times.
  - In the DONE cycle it reflects the new product, and stall = 0.
- rd_req and start in the same DONE/IDLE cycle:
  - The read returns the current HI/LO (the just-completed product).
  - start is accepted.
  - No stall.
- Reset mid-RUN: operation aborted, no done pulse, HI/LO = 0.
- srca/srcb changes after the accepting edge have no effect.

Test Plan:
1. Reset: assert reset asynchronously between edges -> busy = done = stall = 0 immediately, rd_data = 0 for rd_sel = 0 and 1.
2. start, srca = 3, srcb = 5 -> busy = 1 for 32 cycles, done = 1 in the 33rd cycle after the accept edge; rd_sel = 0 gives 0x0000000F, rd_sel = 1 gives 0x00000000.
3. srca = srcb = 0xFFFFFFFF -> after done, HI = 0xFFFFFFFE, LO = 0x00000001. Also srca = 0x80000000, srcb = 2 -> HI = 0x00000001, LO = 0.
4. Hold rd_req = 1, rd_sel = 1 from the cycle after accept -> stall = 1 every RUN cycle, stall = 0 in the DONE cycle with rd_data = new HI. Previous HI is visible during RUN.
5. Operands (7, 9):
   - start = 1 with (2, 2) in RUN cycle 5 -> stall = 1, result still LO = 63.
   - start with (4, 4) in the DONE cycle -> accepted without stall; next done gives LO = 16.
6. Run 0xFFFFFFFF * 0xFFFFFFFF, assert reset in RUN cycle 10 -> busy = 0, no done, HI = LO = 0. Then release reset and multiply 6 * 7 -> LO = 42 after the full latency.
